// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decoder_pkg
// Purpose  : Shared types, constants and decode helper for decoder24_strobe.
// Revision : 1.0 - initial release
// ============================================================================
package decoder_pkg;

  localparam int c_cnt_w   = 8;
  localparam int c_q_depth = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic logic [3:0] decode2to4(input logic [1:0] code);
    logic [3:0] onehot;
    onehot = 4'b0001 << code;
    return onehot;
  endfunction

endpackage
`default_nettype wire

// File: rtl/code_fifo.sv
`default_nettype none
// ============================================================================
// Module   : code_fifo
// Purpose  : Two-entry FIFO of 2-bit codes; occupancy derived from pointers.
// Revision : 1.0 - initial release
// ============================================================================
module code_fifo
  import decoder_pkg::*;
#(
  parameter int DEPTH = c_q_depth
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [1:0] push_code,
  input  logic       pop,
  output logic [1:0] head_code,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  logic [1:0] r_mem [DEPTH];
  // bit 0 addresses the entry, bit 1 is the wrap flag
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic       w_push;
  logic       w_pop;

  assign full      = (r_wr_ptr[0] == r_rd_ptr[0]) && (r_wr_ptr[1] != r_rd_ptr[1]);
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign count     = r_wr_ptr - r_rd_ptr;
  assign head_code = r_mem[r_rd_ptr[0]];
  assign w_push    = push && !full;
  assign w_pop     = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 2'd0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[0]] <= push_code;
        r_wr_ptr           <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/decoder24_strobe.sv
`default_nettype none
// ============================================================================
// Module   : decoder24_strobe
// Purpose  : Queued 2-to-4 decoder emitting fixed-width one-hot strobes.
// Revision : 1.0 - initial release
// ============================================================================
module decoder24_strobe
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int DEPTH       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_code,
  output logic [3:0] y,
  output logic       busy,
  output logic [1:0] count
);

  localparam logic [c_cnt_w-1:0] c_hold_load = c_cnt_w'(HOLD_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_gap_load  = c_cnt_w'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic               c_no_gap    = (GAP_CYCLES == 0);

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [3:0]         r_y;

  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_cnt_done;
  logic [1:0] w_head;

  assign w_push     = in_valid && !w_full;
  assign w_cnt_done = (r_cnt == '0);

  // Pop decision uses registered empty, so a fresh push is never popped on the same edge
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      IDLE:    w_pop = !w_empty;
      HOLD:    w_pop = w_cnt_done && c_no_gap && !w_empty;
      GAP:     w_pop = w_cnt_done && !w_empty;
      default: w_pop = 1'b0;
    endcase
  end

  code_fifo #(
    .DEPTH(DEPTH)
  ) u_code_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (w_push),
    .push_code(in_code),
    .pop      (w_pop),
    .head_code(w_head),
    .full     (w_full),
    .empty    (w_empty),
    .count    (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_y     <= 4'b0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_y     <= decode2to4(w_head);
            r_cnt   <= c_hold_load;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (!w_cnt_done) begin
            r_cnt <= r_cnt - 8'd1;
          end else if (!c_no_gap) begin
            r_y     <= 4'b0000;
            r_cnt   <= c_gap_load;
            r_state <= GAP;
          end else if (!w_empty) begin
            r_y   <= decode2to4(w_head);
            r_cnt <= c_hold_load;
          end else begin
            r_y     <= 4'b0000;
            r_state <= IDLE;
          end
        end
        GAP: begin
          if (!w_cnt_done) begin
            r_cnt <= r_cnt - 8'd1;
          end else if (!w_empty) begin
            r_y     <= decode2to4(w_head);
            r_cnt   <= c_hold_load;
            r_state <= HOLD;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_y     <= 4'b0000;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign y        = r_y;
  assign in_ready = !w_full;
  assign busy     = (r_state != IDLE) || !w_empty;

endmodule
`default_nettype wire
